bip_control_unit: RTL and testbench
===================================

Name: bip_control_unit

Overview:
- Multicycle control unit and sequencer for the BIP I accumulator processor.
- Fetches the 16-bit instruction, decodes opcode and operand, and runs a req/ack handshake with data memory.
- Drives the PC, accumulator, mux-select and ALU controls of the BIP I datapath.
- Provides a halt flag and a cycle counter for the debug path.

Parameters:
OPCODE_W, 5, opcode field width (Instr[15:11])
OPERAND_W, 11, operand/immediate field width (Instr[10:0])
CNT_W, 32, cycle counter width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Enable  in  1  run permission, sampled only in FETCH (debug step/stall)
Instr  in  OPCODE_W+OPERAND_W  program memory data, valid in the DECODE cycle
IMemRd  out  1  program memory read strobe
DMemReq  out  1  data memory request
DMemWe  out  1  data memory write (qualifies DMemReq)
DMemAck  in  1  data memory acknowledge; read data valid in the ack cycle
Operand  out  OPERAND_W  latched IR[10:0]; address or immediate
WrPC  out  1  PC increment enable
SelA  out  2  accumulator source: 00 memory, 01 immediate, 10 ALU
SelB  out  1  ALU operand B: 0 memory, 1 immediate
AluOp  out  1  0 add, 1 subtract
WrAcc  out  1  accumulator write enable
IllegalOp  out  1  one-cycle pulse on undefined opcode
Halted  out  1  high in HALT
CycleCount  out  CNT_W  executed-cycle counter

Behaviour:
- Reset low (asynchronous): state=FETCH, IR=0, CycleCount=0; every output forced to 0 while Reset is low. Operation resumes on the first rising edge after release.
- States and transitions:
  - FETCH: IMemRd=Enable. Enable=1 -> DECODE; Enable=0 -> hold FETCH.
  - DECODE: IR<=Instr. HLT -> HALT; STO/LD/ADD/SUB -> MEM; all others -> EXEC.
  - MEM: DMemReq=1, DMemWe=1 only for STO. Hold MEM until DMemAck=1, then -> EXEC. Request stays asserted every wait cycle; the handshake is never dropped mid-transfer.
  - EXEC: WrPC=1 plus opcode-specific writes for exactly one cycle, then -> FETCH.
  - HALT: Halted=1 and all other controls 0. Only reset exits HALT.
- Opcodes and EXEC actions:
  - 00000 HLT: none (goes to HALT).
  - 00001 STO: WrPC only.
  - 00010 LD: WrAcc, SelA=00. The datapath must capture read data on the ack edge.
  - 00011 LDI: WrAcc, SelA=01.
  - 00100 ADD: WrAcc, SelA=10, SelB=0, AluOp=0.
  - 00101 ADDI: same as ADD but SelB=1.
  - 00110 SUB: WrAcc, SelA=10, SelB=0, AluOp=1.
  - 00111 SUBI: same as SUB but SelB=1.
- Undefined opcodes (01000–11111): executed as NOP. IllegalOp=1 and WrPC=1 in EXEC; no WrAcc, no memory access.
- Latency:
  - Immediate ops and NOP: 3 cycles.
  - Memory ops: 3 + k cycles, where k ≥ 1 is the number of MEM cycles up to and including the ack.
  - HLT: 2 cycles, then HALT.
- Timing of outputs:
  - All controls are Moore outputs decoded from the registered state and IR; no combinational path from Instr.
  - DMemAck affects only the next-state logic.
  - Operand=IR[10:0], stable from the cycle after DECODE until the next DECODE.
- CycleCount:
  - +1 on every clock edge whose current state is not HALT, including FETCH stall cycles.
  - Saturates at all-ones; never wraps.
- Boundary cases:
  - DMemAck outside MEM: ignored.
  - Enable low outside FETCH: no effect.
  - Reset mid-MEM: DMemReq drops asynchronously and the instruction is abandoned.

Test Plan:
- Program LDI 5; ADDI 3; STO 10; HLT, with STO ack on the 3rd MEM cycle -> exact control sequence, Operand=10 with DMemWe=1 during MEM, Halted=1, CycleCount=14 and frozen at 14.
- LD 7 with ack in the 1st MEM cycle -> 4-cycle instruction; EXEC has WrAcc=1, SelA=00, WrPC=1; DMemWe=0 throughout.
- SUB 4 then SUBI 2 -> EXEC shows SelA=10, AluOp=1; SelB=0 for SUB, SelB=1 for SUBI.
- Instr=0xF800 (opcode 11111) -> IllegalOp one-cycle pulse in EXEC, WrPC=1, WrAcc=0, DMemReq never asserted; next FETCH follows.
- Enable=0 for 5 cycles at FETCH -> IMemRd=0, state held, CycleCount advances by 5; Enable=1 resumes fetch.
- Reset pulled low while in MEM with no ack -> all outputs 0 immediately, CycleCount=0; after release the FSM starts in FETCH with IMemRd=1.

Source files
------------

// File: rtl/bip_control_unit.sv
// Multicycle control unit / sequencer for the BIP I accumulator processor.
// Walks FETCH -> DECODE -> [MEM] -> EXEC per instruction, runs the data-memory
// req/ack handshake and drives the PC, accumulator, mux-select and ALU controls.
//
// Ports:
//   Clock, Reset       rising-edge clock, asynchronous active-low reset
//   Enable             run permission, only looked at in FETCH
//   Instr              program memory data, latched into IR in DECODE
//   IMemRd             program memory read strobe
//   DMemReq/DMemWe     data memory request / write qualifier
//   DMemAck            data memory acknowledge (next-state only)
//   Operand            IR operand field (address or immediate)
//   WrPC, SelA, SelB, AluOp, WrAcc   datapath controls, asserted in EXEC
//   IllegalOp          one-cycle pulse in EXEC for an undefined opcode
//   Halted             high in HALT
//   CycleCount         saturating count of non-HALT cycles
module bip_control_unit #(
  parameter int unsigned OPCODE_W  = 5,
  parameter int unsigned OPERAND_W = 11,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic [OPCODE_W+OPERAND_W-1:0] Instr,
  output logic                          IMemRd,
  output logic                          DMemReq,
  output logic                          DMemWe,
  input  logic                          DMemAck,
  output logic [OPERAND_W-1:0]          Operand,
  output logic                          WrPC,
  output logic [1:0]                    SelA,
  output logic                          SelB,
  output logic                          AluOp,
  output logic                          WrAcc,
  output logic                          IllegalOp,
  output logic                          Halted,
  output logic [CNT_W-1:0]              CycleCount
);

  localparam int unsigned InstrW = OPCODE_W + OPERAND_W;

  localparam logic [OPCODE_W-1:0] OpHlt  = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OpSto  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OpLd   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OpLdi  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OpAdd  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OpSub  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OpSubi = OPCODE_W'(7);

  typedef enum logic [2:0] {StFetch, StDecode, StMem, StExec, StHalt} state_e;

  state_e              state_q, state_d;
  logic [InstrW-1:0]   ir_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [OPCODE_W-1:0] ir_op, in_op;

  assign ir_op = ir_q[InstrW-1:OPERAND_W];
  assign in_op = Instr[InstrW-1:OPERAND_W];

  // Next state: decided from the incoming word in DECODE, from IR afterwards.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  if (Enable) state_d = StDecode;
      StDecode: begin
        if (in_op == OpHlt) begin
          state_d = StHalt;
        end else if (in_op == OpSto || in_op == OpLd || in_op == OpAdd || in_op == OpSub) begin
          state_d = StMem;
        end else begin
          state_d = StExec;
        end
      end
      StMem:    if (DMemAck) state_d = StExec;
      StExec:   state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StFetch;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) ir_q <= Instr;
      if (state_q != StHalt && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Raw Moore controls from registered state and IR.
  logic       imem_rd, dmem_req, dmem_we, wr_pc, sel_b, alu_op, wr_acc, illegal, halted;
  logic [1:0] sel_a;

  always_comb begin
    imem_rd  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    wr_pc    = 1'b0;
    sel_a    = 2'b00;
    sel_b    = 1'b0;
    alu_op   = 1'b0;
    wr_acc   = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      StFetch: imem_rd = Enable;
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (ir_op == OpSto);
      end
      StExec: begin
        wr_pc = 1'b1;
        case (ir_op)
          OpHlt, OpSto: ;
          OpLd:   wr_acc = 1'b1;
          OpLdi: begin
            wr_acc = 1'b1;
            sel_a  = 2'b01;
          end
          OpAdd, OpAddi, OpSub, OpSubi: begin
            wr_acc = 1'b1;
            sel_a  = 2'b10;
            sel_b  = (ir_op == OpAddi || ir_op == OpSubi);
            alu_op = (ir_op == OpSub || ir_op == OpSubi);
          end
          default: illegal = 1'b1;  // undefined opcode runs as a NOP
        endcase
      end
      StHalt:  halted = 1'b1;
      default: ;
    endcase
  end

  // Reset gates every output so the processor is quiet while held in reset,
  // even though the FETCH state would otherwise follow Enable.
  assign IMemRd     = Reset & imem_rd;
  assign DMemReq    = Reset & dmem_req;
  assign DMemWe     = Reset & dmem_we;
  assign WrPC       = Reset & wr_pc;
  assign SelA       = Reset ? sel_a : 2'b00;
  assign SelB       = Reset & sel_b;
  assign AluOp      = Reset & alu_op;
  assign WrAcc      = Reset & wr_acc;
  assign IllegalOp  = Reset & illegal;
  assign Halted     = Reset & halted;
  assign Operand    = Reset ? ir_q[OPERAND_W-1:0] : '0;
  assign CycleCount = Reset ? cnt_q : '0;

endmodule

// File: tb/tb_bip_control_unit.sv
// Scoreboard bench for bip_control_unit: expected control vectors are queued as
// each instruction is issued and checked cycle by cycle against the outputs.
module tb_bip_control_unit;

  logic        Clock, Reset, Enable, DMemAck;
  logic [15:0] Instr;
  logic        IMemRd, DMemReq, DMemWe, WrPC, SelB, AluOp, WrAcc, IllegalOp, Halted;
  logic [1:0]  SelA;
  logic [10:0] Operand;
  logic [31:0] CycleCount;

  bip_control_unit dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .Instr      (Instr),
    .IMemRd     (IMemRd),
    .DMemReq    (DMemReq),
    .DMemWe     (DMemWe),
    .DMemAck    (DMemAck),
    .Operand    (Operand),
    .WrPC       (WrPC),
    .SelA       (SelA),
    .SelB       (SelB),
    .AluOp      (AluOp),
    .WrAcc      (WrAcc),
    .IllegalOp  (IllegalOp),
    .Halted     (Halted),
    .CycleCount (CycleCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {IMemRd, DMemReq, DMemWe, WrPC, SelA, SelB, AluOp, WrAcc, IllegalOp, Halted}
  logic [10:0] got_ctrl;
  assign got_ctrl = {IMemRd, DMemReq, DMemWe, WrPC, SelA, SelB, AluOp, WrAcc, IllegalOp, Halted};

  typedef struct packed {
    logic [10:0] ctrl;
    logic        chk_opnd;
    logic [10:0] opnd;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] cv(input logic imem, req, we, wrpc, input logic [1:0] sela,
                                     input logic selb, alu, wracc, ill, halt);
    return {imem, req, we, wrpc, sela, selb, alu, wracc, ill, halt};
  endfunction

  function automatic logic [10:0] exec_exp(input logic [4:0] op);
    case (op)
      5'd1:    return cv(0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);  // STO
      5'd2:    return cv(0, 0, 0, 1, 2'b00, 0, 0, 1, 0, 0);  // LD
      5'd3:    return cv(0, 0, 0, 1, 2'b01, 0, 0, 1, 0, 0);  // LDI
      5'd4:    return cv(0, 0, 0, 1, 2'b10, 0, 0, 1, 0, 0);  // ADD
      5'd5:    return cv(0, 0, 0, 1, 2'b10, 1, 0, 1, 0, 0);  // ADDI
      5'd6:    return cv(0, 0, 0, 1, 2'b10, 0, 1, 1, 0, 0);  // SUB
      5'd7:    return cv(0, 0, 0, 1, 2'b10, 1, 1, 1, 0, 0);  // SUBI
      default: return cv(0, 0, 0, 1, 2'b00, 0, 0, 0, 1, 0);  // illegal -> NOP
    endcase
  endfunction

  function automatic void push(input logic [10:0] ctrl, input logic chk, input logic [10:0] opnd);
    exp_t e;
    e.ctrl = ctrl;
    e.chk_opnd = chk;
    e.opnd = opnd;
    sb.push_back(e);
  endfunction

  // One clock cycle, entered at a falling edge: drive inputs, check, advance.
  task automatic cyc(input logic en, input logic [15:0] ins, input logic ack);
    exp_t e;
    Enable  = en;
    Instr   = ins;
    DMemAck = ack;
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("ctrl", {21'd0, got_ctrl}, {21'd0, e.ctrl});
      if (e.chk_opnd) check("operand", {21'd0, Operand}, {21'd0, e.opnd});
      check("cnt", CycleCount, exp_cnt);
      if (!e.ctrl[0]) exp_cnt++;
    end
    @(negedge Clock);
  endtask

  // Issue one instruction; k = MEM cycle carrying the ack. Enable/ack are
  // deliberately driven in cycles where they must be ignored.
  task automatic run_instr(input logic [15:0] ins, input int k);
    logic [4:0] op;
    logic       mem;
    op  = ins[15:11];
    mem = (op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd6);
    push(cv(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0), 1'b0, 11'd0);
    push(11'd0, 1'b0, 11'd0);
    if (mem)
      for (int i = 0; i < k; i++) push(cv(0, 1, op == 5'd1, 0, 2'b00, 0, 0, 0, 0, 0), 1'b1, ins[10:0]);
    if (op != 5'd0) push(exec_exp(op), 1'b1, ins[10:0]);
    cyc(1'b1, 16'hFFFF, 1'b0);
    cyc(1'b0, ins, 1'b1);
    if (mem)
      for (int i = 0; i < k; i++) cyc(1'b0, 16'hFFFF, i == k - 1);
    if (op != 5'd0) cyc(1'b0, 16'hFFFF, 1'b1);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      push(cv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1), 1'b0, 11'd0);
      cyc(1'b1, 16'hFFFF, 1'b1);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Enable = 1'b1;
    DMemAck = 1'b1;
    Instr = 16'hFFFF;
    #1;
    check("rst_ctrl", {21'd0, got_ctrl}, 32'd0);
    check("rst_cnt", CycleCount, 32'd0);
    check("rst_opnd", {21'd0, Operand}, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    exp_cnt = 0;
    sb.delete();
  endtask

  initial begin
    Reset = 1'b0;
    Enable = 1'b0;
    DMemAck = 1'b0;
    Instr = 16'h0000;

    // Program LDI 5; ADDI 3; STO 10 (ack on 3rd MEM cycle); HLT
    do_reset();
    run_instr(16'h1805, 1);
    run_instr(16'h2803, 1);
    run_instr(16'h080A, 3);
    run_instr(16'h0000, 1);
    halt_cycles(1);
    check("cnt_halt", CycleCount, 32'd14);
    halt_cycles(3);
    check("cnt_frozen", CycleCount, 32'd14);

    // LD 7 ack in 1st MEM cycle, SUB 4, SUBI 2, illegal opcode, stall, LDI
    do_reset();
    run_instr(16'h1007, 1);
    run_instr(16'h3004, 2);
    run_instr(16'h3802, 1);
    run_instr(16'hF800, 1);
    begin
      int c0;
      c0 = exp_cnt;
      for (int i = 0; i < 5; i++) begin
        push(11'd0, 1'b0, 11'd0);
        cyc(1'b0, 16'hFFFF, 1'b1);
      end
      #1;
      check("stall_cnt", CycleCount, c0 + 5);
    end
    run_instr(16'h1809, 1);
    run_instr(16'h2001, 4);

    // Reset while waiting in MEM with no ack
    do_reset();
    push(cv(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0), 1'b0, 11'd0);
    push(11'd0, 1'b0, 11'd0);
    push(cv(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0), 1'b1, 11'd1);
    push(cv(0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0), 1'b1, 11'd1);
    cyc(1'b1, 16'hFFFF, 1'b0);
    cyc(1'b0, 16'h1001, 1'b0);
    cyc(1'b0, 16'hFFFF, 1'b0);
    cyc(1'b0, 16'hFFFF, 1'b0);
    Reset = 1'b0;
    #1;
    check("mid_rst_ctrl", {21'd0, got_ctrl}, 32'd0);
    check("mid_rst_cnt", CycleCount, 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    exp_cnt = 0;
    sb.delete();
    run_instr(16'h1803, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
